fractal_scan: RTL

FRACTAL_SCAN -- requirements
Module: fractal_scan

---
 rtl/fractal_scan.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/fractal_scan.sv
// rtl/fractal_scan.sv - Raster-scan sequencer feeding a Mandelbrot/Julia iteration ALU
//
// Walks a WIDTH x HEIGHT pixel grid starting at (cr_offset, ci_offset).
// Each pixel coordinate advances by step+1 per pixel (x) and per row (y).
// For each pixel the block repeatedly issues one-cycle alu_start requests,
// feeding the returned z back, until the ALU reports escape/overflow or the
// iteration count reaches max_ctr. It then presents the shifted count as a
// pixel on a valid/ready handshake.
//
// Optional feature macro: FRACTAL_SCAN_JULIA_EN
//   defined   : julia=1 selects Julia mode (c = jr/ji, z0 = pixel coordinate)
//   undefined : julia/jr/ji are present but ignored; always Mandelbrot
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   run, running, frame_done    frame start request and frame status
//   julia, jr, ji               mode select and Julia constant
//   max_ctr, ctr_shift          iteration limit, count-to-pixel right shift
//   step, cr_offset, ci_offset  coordinate increment-minus-one, frame origin
//   alu_start, alu_finished     iteration request / result valid
//   alu_cr/ci/zr/zi             ALU operands
//   alu_out_zr/zi, alu_size,
//   alu_overflow                ALU results
//   pix_valid, pix_ready,
//   pix_value, pix_x, pix_y     pixel output stream

module fractal_scan #(
    parameter int BITWIDTH  = 10,
    parameter int CTRWIDTH  = 7,
    parameter int WIDTH     = 320,
    parameter int HEIGHT    = 240,
    parameter int STEPWIDTH = 7,
    parameter int OUTWIDTH  = 4,
    localparam int SHW      = (CTRWIDTH > 1) ? $clog2(CTRWIDTH) : 1,
    localparam int XW       = (WIDTH > 1)    ? $clog2(WIDTH)    : 1,
    localparam int YW       = (HEIGHT > 1)   ? $clog2(HEIGHT)   : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                running,
    output logic                frame_done,
    input  logic                julia,
    input  logic [BITWIDTH-1:0] jr,
    input  logic [BITWIDTH-1:0] ji,
    input  logic [CTRWIDTH-1:0] max_ctr,
    input  logic [SHW-1:0]      ctr_shift,
    input  logic [STEPWIDTH-1:0] step,
    input  logic [BITWIDTH-1:0] cr_offset,
    input  logic [BITWIDTH-1:0] ci_offset,
    output logic                alu_start,
    input  logic                alu_finished,
    output logic [BITWIDTH-1:0] alu_cr,
    output logic [BITWIDTH-1:0] alu_ci,
    output logic [BITWIDTH-1:0] alu_zr,
    output logic [BITWIDTH-1:0] alu_zi,
    input  logic [BITWIDTH-1:0] alu_out_zr,
    input  logic [BITWIDTH-1:0] alu_out_zi,
    input  logic                alu_size,
    input  logic                alu_overflow,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [OUTWIDTH-1:0] pix_value,
    output logic [XW-1:0]       pix_x,
    output logic [YW-1:0]       pix_y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        EMIT  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [BITWIDTH-1:0] pc_q, pc_d;
    logic [BITWIDTH-1:0] pi_q, pi_d;
    logic [BITWIDTH-1:0] zr_q, zr_d;
    logic [BITWIDTH-1:0] zi_q, zi_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [CTRWIDTH-1:0] ctr_q, ctr_d;

    logic                running_d, frame_done_d, alu_start_d, pix_valid_d;
    logic [BITWIDTH-1:0] alu_cr_d, alu_ci_d, alu_zr_d, alu_zi_d;
    logic [OUTWIDTH-1:0] pix_value_d;
    logic [XW-1:0]       pix_x_d;
    logic [YW-1:0]       pix_y_d;

    logic julia_mode;
`ifdef FRACTAL_SCAN_JULIA_EN
    assign julia_mode = julia;
`else
    assign julia_mode = 1'b0;
    wire unused_julia = &{1'b0, julia, jr, ji};
`endif

    // Coordinate increment is step+1 with step zero-extended; all coordinate
    // arithmetic wraps modulo 2^BITWIDTH.
    logic [BITWIDTH-1:0] step_inc;
    assign step_inc = BITWIDTH'(step) + BITWIDTH'(1);

    logic last_x, last_y;
    assign last_x = (x_q == XW'(WIDTH - 1));
    assign last_y = (y_q == YW'(HEIGHT - 1));

    // Raster position and coordinate of the pixel after the current one.
    logic [BITWIDTH-1:0] nx_pc, nx_pi;
    logic [XW-1:0]       nx_x;
    logic [YW-1:0]       nx_y;
    assign nx_pc = last_x ? cr_offset : pc_q + step_inc;
    assign nx_pi = last_x ? pi_q + step_inc : pi_q;
    assign nx_x  = last_x ? '0 : x_q + XW'(1);
    assign nx_y  = last_x ? y_q + YW'(1) : y_q;

    logic [CTRWIDTH-1:0] ctr_shifted;
    assign ctr_shifted = ctr_q >> ctr_shift;
    wire unused_bits = &{1'b0, ctr_shifted};

    logic escape;
    assign escape = alu_size || alu_overflow || (ctr_q == max_ctr);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pi_d         = pi_q;
        zr_d         = zr_q;
        zi_d         = zi_q;
        x_d          = x_q;
        y_d          = y_q;
        ctr_d        = ctr_q;
        running_d    = running;
        frame_done_d = frame_done;
        alu_start_d  = 1'b0;
        alu_cr_d     = alu_cr;
        alu_ci_d     = alu_ci;
        alu_zr_d     = alu_zr;
        alu_zi_d     = alu_zi;
        pix_valid_d  = pix_valid;
        pix_value_d  = pix_value;
        pix_x_d      = pix_x;
        pix_y_d      = pix_y;

        case (state_q)
            IDLE: begin
                if (run) begin
                    pc_d         = cr_offset;
                    pi_d         = ci_offset;
                    x_d          = '0;
                    y_d          = '0;
                    ctr_d        = '0;
                    zr_d         = julia_mode ? cr_offset : '0;
                    zi_d         = julia_mode ? ci_offset : '0;
                    frame_done_d = 1'b0;
                    running_d    = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                alu_start_d = 1'b1;
                alu_cr_d    = julia_mode ? jr : pc_q;
                alu_ci_d    = julia_mode ? ji : pi_q;
                alu_zr_d    = zr_q;
                alu_zi_d    = zi_q;
                state_d     = WAIT;
            end
            WAIT: begin
                if (alu_finished) begin
                    if (escape) begin
                        pix_valid_d = 1'b1;
                        pix_value_d = ctr_shifted[OUTWIDTH-1:0];
                        pix_x_d     = x_q;
                        pix_y_d     = y_q;
                        state_d     = EMIT;
                    end else begin
                        zr_d    = alu_out_zr;
                        zi_d    = alu_out_zi;
                        ctr_d   = ctr_q + CTRWIDTH'(1);
                        state_d = ISSUE;
                    end
                end
            end
            EMIT: begin
                if (pix_ready) begin
                    pix_valid_d = 1'b0;
                    ctr_d       = '0;
                    x_d         = nx_x;
                    y_d         = nx_y;
                    pc_d        = nx_pc;
                    pi_d        = nx_pi;
                    // Julia starts each pixel with z at that pixel's coordinate.
                    zr_d        = julia_mode ? nx_pc : '0;
                    zi_d        = julia_mode ? nx_pi : '0;
                    if (last_x && last_y) begin
                        frame_done_d = 1'b1;
                        running_d    = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= '0;
            pi_q       <= '0;
            zr_q       <= '0;
            zi_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            ctr_q      <= '0;
            running    <= 1'b0;
            frame_done <= 1'b1;
            alu_start  <= 1'b0;
            alu_cr     <= '0;
            alu_ci     <= '0;
            alu_zr     <= '0;
            alu_zi     <= '0;
            pix_valid  <= 1'b0;
            pix_value  <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
        end else begin
            pc_q       <= pc_d;
            pi_q       <= pi_d;
            zr_q       <= zr_d;
            zi_q       <= zi_d;
            x_q        <= x_d;
            y_q        <= y_d;
            ctr_q      <= ctr_d;
            running    <= running_d;
            frame_done <= frame_done_d;
            alu_start  <= alu_start_d;
            alu_cr     <= alu_cr_d;
            alu_ci     <= alu_ci_d;
            alu_zr     <= alu_zr_d;
            alu_zi     <= alu_zi_d;
            pix_valid  <= pix_valid_d;
            pix_value  <= pix_value_d;
            pix_x      <= pix_x_d;
            pix_y      <= pix_y_d;
        end
    end

endmodule
